// File: rtl/pwm_ramp_sequencer_if.sv
// Bus bundles for the PWM ramp sequencer: an Avalon-MM style configuration slave
// and the master write port that programs the downstream PWM block.
interface pwm_ramp_sequencer_avs_if;
    logic        avs_s0_chip_select;
    logic        avs_s0_read;
    logic        avs_s0_write;
    logic [2:0]  avs_s0_address;
    logic [31:0] avs_s0_writedata;
    logic [31:0] avs_s0_readdata;

    modport master (
        output avs_s0_chip_select, avs_s0_read, avs_s0_write, avs_s0_address, avs_s0_writedata,
        input  avs_s0_readdata
    );
    modport slave (
        input  avs_s0_chip_select, avs_s0_read, avs_s0_write, avs_s0_address, avs_s0_writedata,
        output avs_s0_readdata
    );
endinterface

interface pwm_ramp_sequencer_avm_if;
    logic [1:0]  avm_m0_address;
    logic        avm_m0_write;
    logic [31:0] avm_m0_writedata;
    logic [3:0]  avm_m0_byteenable;
    logic        avm_m0_waitrequest;

    modport master (
        output avm_m0_address, avm_m0_write, avm_m0_writedata, avm_m0_byteenable,
        input  avm_m0_waitrequest
    );
    modport slave (
        input  avm_m0_address, avm_m0_write, avm_m0_writedata, avm_m0_byteenable,
        output avm_m0_waitrequest
    );
endinterface

// File: rtl/pwm_ramp_sequencer.sv
// Ramps a PWM block's width from START_WIDTH to END_WIDTH in STEP increments,
// holding each width for INTERVAL cycles, then raises a sticky done interrupt.
module pwm_ramp_sequencer #(
    parameter logic [31:0] RST_PERIOD    = 32'd500000,
    parameter logic [31:0] RST_END_WIDTH = 32'd250000,
    parameter logic [31:0] RST_STEP      = 32'd1000,
    parameter logic [31:0] RST_INTERVAL  = 32'd50000
) (
    input  logic                            csi_clk,
    input  logic                            rsi_rst,
    pwm_ramp_sequencer_avs_if.slave         avs_s0,
    pwm_ramp_sequencer_avm_if.master        avm_m0,
    output logic                            irq
);

    typedef enum logic [2:0] {
        IDLE, WR_PERIOD, WR_WIDTH, WR_EN_ON, WAIT, STEP, WR_EN_OFF, DONE
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] period_q, startWidth_q, endWidth_q, step_q, interval_q;
    logic [31:0] cur_q, cur_d;
    logic [31:0] waitCnt_q, waitCnt_d;
    logic [31:0] readdata_q;
    logic        done_q, done_d, irq_q, irq_d;
    logic        stopPend_q, stopPend_d, firstPass_q, firstPass_d;

    logic        cfgWr, ctrlWr, startCmd, stopCmd, irqClr, busy, accepted, stopSeen;
    logic [31:0] intervalEff, gap, stepNext, readMux;
    logic        mWrite;
    logic [1:0]  mAddr;
    logic [31:0] mData;

    assign cfgWr    = avs_s0.avs_s0_chip_select & avs_s0.avs_s0_write;
    assign ctrlWr   = cfgWr && (avs_s0.avs_s0_address == 3'd0);
    // A combined start+stop write is treated purely as a stop.
    assign startCmd = ctrlWr & avs_s0.avs_s0_writedata[0] & ~avs_s0.avs_s0_writedata[1];
    assign stopCmd  = ctrlWr & avs_s0.avs_s0_writedata[1];
    assign irqClr   = ctrlWr & avs_s0.avs_s0_writedata[2];
    assign busy     = (state_q != IDLE) && (state_q != DONE);
    assign accepted = ~avm_m0.avm_m0_waitrequest;
    assign stopSeen = stopCmd | stopPend_q;
    assign intervalEff = (interval_q == 32'd0) ? 32'd1 : interval_q;

    // Distance-based stepping saturates at END_WIDTH without any overflow or wrap.
    always_comb begin
        gap      = '0;
        stepNext = endWidth_q;
        if (step_q != 32'd0) begin
            if (cur_q < endWidth_q) begin
                gap = endWidth_q - cur_q;
                if (step_q < gap) stepNext = cur_q + step_q;
            end else if (cur_q > endWidth_q) begin
                gap = cur_q - endWidth_q;
                if (step_q < gap) stepNext = cur_q - step_q;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        done_d      = done_q;
        irq_d       = irq_q & ~irqClr;
        stopPend_d  = stopPend_q;
        firstPass_d = firstPass_q;
        waitCnt_d   = waitCnt_q;
        mWrite      = 1'b0;
        mAddr       = 2'd0;
        mData       = 32'd0;
        case (state_q)
            IDLE, DONE: begin
                if (stopCmd && state_q == DONE) begin
                    done_d  = 1'b0;
                    state_d = WR_EN_OFF;
                end else if (startCmd) begin
                    cur_d       = startWidth_q;
                    done_d      = 1'b0;
                    irq_d       = 1'b0;
                    firstPass_d = 1'b1;
                    stopPend_d  = 1'b0;
                    state_d     = WR_PERIOD;
                end
            end
            WR_PERIOD, WR_WIDTH, WR_EN_ON: begin
                mWrite = 1'b1;
                mAddr  = (state_q == WR_PERIOD) ? 2'd1 : (state_q == WR_WIDTH) ? 2'd0 : 2'd2;
                mData  = (state_q == WR_PERIOD) ? period_q : (state_q == WR_WIDTH) ? cur_q : 32'd1;
                if (!accepted) begin
                    stopPend_d = stopSeen;
                end else begin
                    stopPend_d = 1'b0;
                    waitCnt_d  = 32'd0;
                    if (state_q == WR_EN_ON) firstPass_d = 1'b0;
                    if (stopSeen)                              state_d = WR_EN_OFF;
                    else if (state_q == WR_PERIOD)             state_d = WR_WIDTH;
                    else if (state_q == WR_WIDTH && firstPass_q) state_d = WR_EN_ON;
                    else                                       state_d = WAIT;
                end
            end
            WAIT: begin
                if (stopCmd) begin
                    state_d = WR_EN_OFF;
                end else if (waitCnt_q >= intervalEff - 32'd1) begin
                    if (cur_q == endWidth_q) begin
                        done_d  = 1'b1;
                        irq_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = STEP;
                    end
                end else begin
                    waitCnt_d = waitCnt_q + 32'd1;
                end
            end
            STEP: begin
                if (stopCmd) begin
                    state_d = WR_EN_OFF;
                end else begin
                    cur_d   = stepNext;
                    state_d = WR_WIDTH;
                end
            end
            WR_EN_OFF: begin
                mWrite = 1'b1;
                mAddr  = 2'd2;
                if (accepted) begin
                    done_d     = 1'b0;
                    stopPend_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        readMux = 32'd0;
        case (avs_s0.avs_s0_address)
            3'd0: readMux = {30'd0, done_q, busy};
            3'd1: readMux = period_q;
            3'd2: readMux = startWidth_q;
            3'd3: readMux = endWidth_q;
            3'd4: readMux = step_q;
            3'd5: readMux = interval_q;
            3'd6: readMux = cur_q;
            default: readMux = 32'd0;
        endcase
    end

    always_ff @(posedge csi_clk) begin
        if (rsi_rst) begin
            state_q      <= IDLE;
            cur_q        <= 32'd0;
            done_q       <= 1'b0;
            irq_q        <= 1'b0;
            stopPend_q   <= 1'b0;
            firstPass_q  <= 1'b0;
            waitCnt_q    <= 32'd0;
            readdata_q   <= 32'd0;
            period_q     <= RST_PERIOD;
            startWidth_q <= 32'd0;
            endWidth_q   <= RST_END_WIDTH;
            step_q       <= RST_STEP;
            interval_q   <= RST_INTERVAL;
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            done_q      <= done_d;
            irq_q       <= irq_d;
            stopPend_q  <= stopPend_d;
            firstPass_q <= firstPass_d;
            waitCnt_q   <= waitCnt_d;
            if (avs_s0.avs_s0_chip_select && avs_s0.avs_s0_read) readdata_q <= readMux;
            if (cfgWr && !busy) begin
                case (avs_s0.avs_s0_address)
                    3'd1: period_q     <= avs_s0.avs_s0_writedata;
                    3'd2: startWidth_q <= avs_s0.avs_s0_writedata;
                    3'd3: endWidth_q   <= avs_s0.avs_s0_writedata;
                    3'd4: step_q       <= avs_s0.avs_s0_writedata;
                    3'd5: interval_q   <= avs_s0.avs_s0_writedata;
                    default: ;
                endcase
            end
        end
    end

    // The master strobe is gated by reset so an in-flight write drops in the reset cycle.
    assign avm_m0.avm_m0_write      = mWrite & ~rsi_rst;
    assign avm_m0.avm_m0_address    = mAddr;
    assign avm_m0.avm_m0_writedata  = mData;
    assign avm_m0.avm_m0_byteenable = 4'hF;
    assign avs_s0.avs_s0_readdata   = readdata_q;
    assign irq                      = irq_q;

endmodule

// File: doc/pwm_ramp_sequencer.md
PWM_RAMP_SEQUENCER -- requirements
Module: pwm_ramp_sequencer

Interface
REQ-001 Parameter RST_PERIOD, default 500000, SHALL be the reset value of the PERIOD register.
REQ-002 Parameter RST_END_WIDTH, default 250000, SHALL be the reset value of the END_WIDTH register.
REQ-003 Parameter RST_STEP, default 1000, SHALL be the reset value of the STEP register.
REQ-004 Parameter RST_INTERVAL, default 50000, SHALL be the reset value of the INTERVAL register.
REQ-005 csi_clk  in  1  SHALL be the single clock; all logic on its rising edge.
REQ-006 rsi_rst  in  1  SHALL be the synchronous, active-high reset.
REQ-007 avs_s0_chip_select, avs_s0_read, avs_s0_write  in  1 each  SHALL be the configuration slave strobes.
REQ-008 avs_s0_address  in  3  SHALL select the slave register.
REQ-009 avs_s0_writedata  in  32 / avs_s0_readdata  out  32  SHALL be the slave data buses.
REQ-010 avm_m0_address  out  2  SHALL be the PWM-block register address: 0 width, 1 period, 2 enable.
REQ-011 avm_m0_write  out  1 / avm_m0_writedata  out  32 / avm_m0_byteenable  out  4  SHALL be the master write port; byteenable is constant 4'hF.
REQ-012 avm_m0_waitrequest  in  1  SHALL stall the master write.
REQ-013 irq  out  1  SHALL be the sticky done interrupt.

Function
REQ-014 Slave map: 0 CTRL (W bit0 start, bit1 stop, bit2 irq-clear; R bit0 busy, bit1 done), 1 PERIOD, 2 START_WIDTH, 3 END_WIDTH, 4 STEP, 5 INTERVAL, 6 CUR_WIDTH (read-only); addresses 7 and 6 SHALL ignore writes, and 7 SHALL read 0.
REQ-015 Reads SHALL return data registered one cycle after the read strobe; readdata SHALL hold its value otherwise.
REQ-016 Writes to addresses 1-5 while busy SHALL be ignored; CTRL SHALL always be writable.
REQ-017 FSM states: IDLE, WR_PERIOD, WR_WIDTH, WR_EN_ON, WAIT, STEP, WR_EN_OFF, DONE.
REQ-018 IDLE/DONE + start: cur <= START_WIDTH, done <= 0, irq <= 0, then -> WR_PERIOD -> WR_WIDTH -> WR_EN_ON -> WAIT; start in any other state SHALL be ignored.
REQ-019 Each WR_* state SHALL assert avm_m0_write with a stable address and data until the first cycle waitrequest=0, then advance on the next edge.
REQ-020 WR_PERIOD writes PERIOD to addr 1, WR_WIDTH writes cur to addr 0, WR_EN_ON writes 1 to addr 2, and WR_EN_OFF writes 0 to addr 2.
REQ-021 WAIT SHALL count max(INTERVAL,1) cycles, then go to DONE (done <= 1, irq <= 1) if cur == END_WIDTH, else to STEP.
REQ-022 STEP (1 cycle) SHALL move cur toward END_WIDTH by STEP with unsigned 33-bit arithmetic, saturating exactly at END_WIDTH with no overshoot or wrap; STEP = 0 SHALL set cur to END_WIDTH; it then goes to WR_WIDTH, and WR_WIDTH SHALL return to WAIT after the first pass.
REQ-023 Stop in WAIT/STEP SHALL go to WR_EN_OFF; stop during a WR_* state SHALL complete that write, then go to WR_EN_OFF; WR_EN_OFF SHALL return to IDLE with done=0.
REQ-024 Stop in DONE SHALL go to WR_EN_OFF; stop in IDLE SHALL have no effect.
REQ-025 Start and stop in the same write SHALL act as stop only.
REQ-026 busy SHALL be 1 in every state except IDLE and DONE.
REQ-027 irq-clear SHALL clear irq only; done SHALL be cleared only by start or stop.
REQ-028 DONE SHALL leave the PWM block enabled at END_WIDTH with no master writes.

Reset
REQ-029 While rsi_rst is high at an edge, the block SHALL enter state IDLE, with avm_m0_write, irq, done, busy, readdata and cur at 0.
REQ-030 Reset SHALL load PERIOD, END_WIDTH, STEP and INTERVAL from their parameters, and START_WIDTH with 0.
REQ-031 Reset mid-transfer SHALL drop avm_m0_write immediately, with no enable-off write issued.

Verification
REQ-032 Defaults, waitrequest=0, INTERVAL=4, start -> writes (1,500000),(0,0),(2,1); then width writes 1000,2000,...,250000 spaced 4+2 cycles; then done=1, irq=1.
REQ-033 START=10, END=25, STEP=10 -> width writes 10, 20, 25; no value above 25 is written; done is set.
REQ-034 START=300, END=100, STEP=150 -> width writes 300, 150, 100 (down-ramp, saturated).
REQ-035 waitrequest held high 7 cycles during WR_PERIOD -> address and data stable for all 8 cycles; exactly one write is accepted.
REQ-036 Stop during WR_WIDTH with waitrequest high -> width write completes, then (2,0) is written, then IDLE with busy=0, done=0.
REQ-037 Write PERIOD while busy -> readback is unchanged; CUR_WIDTH readback tracks the last width written with 1-cycle read latency.
